// File: rtl/taxi_ram_rd_stream_pkg.sv
// Shared constants and helpers for the RAM read streamer and its output FIFO.
package taxi_ram_rd_stream_pkg;

    localparam int FIFO_DEPTH = 3;

    typedef logic [1:0] fifo_count_t;
    typedef logic [1:0] fifo_ptr_t;
    typedef logic [2:0] credit_t;

    // Reads may be issued only while buffered beats plus the read in flight stay below this.
    localparam credit_t CREDIT_LIMIT = 3'(FIFO_DEPTH);

    function automatic fifo_ptr_t fifo_ptr_next(input fifo_ptr_t ptr);
        return (ptr == 2'(FIFO_DEPTH - 1)) ? '0 : ptr + 2'd1;
    endfunction

endpackage

// File: rtl/taxi_ram_rd_stream_fifo.sv
// Three-entry register FIFO holding {last, data} beats between the RAM read port and the stream.
module taxi_ram_rd_stream_fifo
    import taxi_ram_rd_stream_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            push,
    input  logic [DATA_W:0] push_data,
    input  logic            pop,
    output logic [DATA_W:0] head_data,
    output fifo_count_t     count
);

    logic [DATA_W:0] mem_q [FIFO_DEPTH];
    fifo_ptr_t       wr_ptr_q;
    fifo_ptr_t       rd_ptr_q;
    fifo_count_t     count_q;
    logic            do_push;
    logic            do_pop;

    assign do_pop  = pop && (count_q != '0);
    assign do_push = push && ((count_q != 2'(FIFO_DEPTH)) || do_pop);

    // NOTE: the storage is reset as well, so m_tdata/m_tlast read zero straight out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= push_data;
                wr_ptr_q        <= fifo_ptr_next(wr_ptr_q);
            end
            if (do_pop) begin
                rd_ptr_q <= fifo_ptr_next(rd_ptr_q);
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 2'd1;
                2'b01:   count_q <= count_q - 2'd1;
                default: count_q <= count_q;
            endcase
        end
    end

    assign head_data = mem_q[rd_ptr_q];
    assign count     = count_q;

endmodule

// File: rtl/taxi_ram_rd_stream.sv
// Plays a (base address, length) region of a registered-read RAM back as a valid/ready stream.
module taxi_ram_rd_stream
    import taxi_ram_rd_stream_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16,
    parameter int LEN_W  = ADDR_W + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    output logic              ram_rd_en,
    output logic [ADDR_W-1:0] ram_rd_addr,
    input  logic [DATA_W-1:0] ram_rd_data,
    output logic [DATA_W-1:0] m_tdata,
    output logic              m_tvalid,
    input  logic              m_tready,
    output logic              m_tlast,
    output logic              busy
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_READ = 1'b1;

    logic [0:0]        state_q;
    logic [0:0]        state_d;
    logic              cmd_ready_q;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] last_addr_q;
    logic [LEN_W-1:0]  remaining_q;
    logic              inflight_q;
    logic              rd_last_q;

    logic              cmd_start;
    logic              issue;
    logic              issue_last;
    credit_t           credit_used;
    fifo_count_t       fifo_count;
    logic [DATA_W:0]   fifo_head;

    assign cmd_start   = cmd_valid && cmd_ready_q && (cmd_len != '0);
    // Credit uses only registered state, so m_tready never reaches the RAM port combinationally.
    assign credit_used = credit_t'(fifo_count) + credit_t'(inflight_q);
    assign issue       = (state_q == ST_READ) && (credit_used < CREDIT_LIMIT);
    assign issue_last  = issue && (remaining_q == LEN_W'(1));

    // NOTE: state_d gets a default before the case so no latch is inferred.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (cmd_start)  state_d = ST_READ;
            ST_READ: if (issue_last) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cmd_ready_q <= 1'b0;
            addr_q      <= '0;
            last_addr_q <= '0;
            remaining_q <= '0;
            inflight_q  <= 1'b0;
            rd_last_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cmd_ready_q <= (state_d == ST_IDLE);
            inflight_q  <= issue;
            rd_last_q   <= issue_last;
            if (cmd_start) begin
                addr_q      <= cmd_addr;
                remaining_q <= cmd_len;
            end else if (issue) begin
                addr_q      <= addr_q + 1'b1;
                remaining_q <= remaining_q - 1'b1;
                last_addr_q <= addr_q;
            end
        end
    end

    // The beat read last cycle lands on ram_rd_data now and is pushed with its last tag.
    taxi_ram_rd_stream_fifo #(
        .DATA_W (DATA_W)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (inflight_q),
        .push_data ({rd_last_q, ram_rd_data}),
        .pop       (m_tvalid && m_tready),
        .head_data (fifo_head),
        .count     (fifo_count)
    );

    assign cmd_ready   = cmd_ready_q;
    assign ram_rd_en   = issue;
    assign ram_rd_addr = issue ? addr_q : last_addr_q;
    assign m_tvalid    = (fifo_count != '0);
    assign m_tdata     = fifo_head[DATA_W-1:0];
    assign m_tlast     = fifo_head[DATA_W];
    assign busy        = (state_q == ST_READ) || inflight_q || m_tvalid;

endmodule

// File: tb/tb_taxi_ram_rd_stream.sv
// Bench for taxi_ram_rd_stream: behavioural RAM with mem[i]=i, scoreboard of expected beats.
module tb_taxi_ram_rd_stream;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 16;
    localparam int LEN_W  = ADDR_W + 1;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [ADDR_W-1:0] cmd_addr = '0;
    logic [LEN_W-1:0]  cmd_len = '0;
    logic              cmd_valid = 1'b0;
    logic              cmd_ready;
    logic              ram_rd_en;
    logic [ADDR_W-1:0] ram_rd_addr;
    logic [DATA_W-1:0] ram_rd_data = '0;
    logic [DATA_W-1:0] m_tdata;
    logic              m_tvalid;
    logic              m_tready = 1'b0;
    logic              m_tlast;
    logic              busy;

    typedef struct {
        logic [DATA_W-1:0] data;
        logic              last;
    } beat_t;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [LEN_W-1:0]  len;
        int                exp_lat;
        logic [DATA_W-1:0] exp_last_data;
    } vec_t;

    beat_t exp_q[$];
    vec_t  vecs[5];

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;

    int beats, lasts_seen, rd_count, ready_low, busy_cyc, stall_changed;
    int first_beat_cyc, last_beat_cyc, last_rd_cyc;
    logic [DATA_W-1:0] last_beat_data;
    logic              stall_prev = 1'b0;
    logic [DATA_W:0]   stall_word = '0;

    taxi_ram_rd_stream #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .LEN_W  (LEN_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cmd_addr    (cmd_addr),
        .cmd_len     (cmd_len),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .ram_rd_en   (ram_rd_en),
        .ram_rd_addr (ram_rd_addr),
        .ram_rd_data (ram_rd_data),
        .m_tdata     (m_tdata),
        .m_tvalid    (m_tvalid),
        .m_tready    (m_tready),
        .m_tlast     (m_tlast),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // RAM preloaded with mem[i] = i, one-cycle registered read.
    always @(posedge clk) begin
        if (ram_rd_en) ram_rd_data <= DATA_W'(ram_rd_addr);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor at the falling edge: counts activity and scores every handshaken beat.
    always @(negedge clk) begin
        if (rst_n) begin
            if (ram_rd_en) begin
                rd_count++;
                last_rd_cyc = cyc;
            end
            if (!cmd_ready) ready_low++;
            if (busy) busy_cyc++;
            if (m_tvalid && !m_tready) begin
                if (stall_prev && ({m_tlast, m_tdata} !== stall_word)) stall_changed++;
                stall_prev = 1'b1;
                stall_word = {m_tlast, m_tdata};
            end else begin
                stall_prev = 1'b0;
            end
            if (m_tvalid && m_tready) begin
                beats++;
                if (m_tlast) lasts_seen++;
                if (first_beat_cyc < 0) first_beat_cyc = cyc;
                last_beat_cyc  = cyc;
                last_beat_data = m_tdata;
                check("beat_expected", 32'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    beat_t e;
                    e = exp_q.pop_front();
                    check("beat_data", m_tdata, e.data);
                    check("beat_last", m_tlast, e.last);
                end
            end
        end
    end

    task automatic clear_counters();
        beats = 0; lasts_seen = 0; rd_count = 0; ready_low = 0; busy_cyc = 0;
        stall_changed = 0; first_beat_cyc = -1; last_beat_cyc = -1; last_rd_cyc = -1;
        last_beat_data = '0;
    endtask

    // Called just after a rising edge; returns the cycle in which the handshake happened.
    task automatic send_cmd(input logic [ADDR_W-1:0] a, input logic [LEN_W-1:0] l, output int acc_cyc);
        int t = 0;
        while (!cmd_ready && t < 100) begin
            @(posedge clk); #1;
            t++;
        end
        check("cmd_ready_wait", 32'(cmd_ready), 1);
        cmd_valid = 1'b1;
        cmd_addr  = a;
        cmd_len   = l;
        acc_cyc   = cyc;
        for (int i = 0; i < int'(l); i++) begin
            exp_q.push_back('{data: DATA_W'(int'(a) + i), last: (i == int'(l) - 1)});
        end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic drain(input string tag);
        int t = 0;
        while ((exp_q.size() != 0 || busy) && t < 300) begin
            @(posedge clk); #1;
            t++;
        end
        check({tag, "_drained"}, 32'(t < 300), 1);
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_cmd_ready"}, 32'(cmd_ready), 0);
        check({tag, "_m_tvalid"}, 32'(m_tvalid), 0);
        check({tag, "_m_tlast"}, 32'(m_tlast), 0);
        check({tag, "_m_tdata"}, 32'(m_tdata), 0);
        check({tag, "_ram_rd_en"}, 32'(ram_rd_en), 0);
        check({tag, "_ram_rd_addr"}, 32'(ram_rd_addr), 0);
        check({tag, "_busy"}, 32'(busy), 0);
    endtask

    initial begin
        int acc, acc2, rel, t;

        vecs[0] = '{16'h0010, 17'd4, 3, 16'h0013};
        vecs[1] = '{16'hFFFE, 17'd4, 3, 16'h0001};
        vecs[2] = '{16'h0000, 17'd0, 0, 16'h0000};
        vecs[3] = '{16'h1234, 17'd1, 3, 16'h1234};
        vecs[4] = '{16'h0100, 17'd7, 3, 16'h0106};

        clear_counters();

        // Reset values, then cmd_ready rising on the first edge after release.
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("rst");
        #3 rst_n = 1'b1;
        #1 check("ready_before_edge", 32'(cmd_ready), 0);
        @(posedge clk); #1;
        check("ready_after_edge", 32'(cmd_ready), 1);

        // Table-driven commands with the stream always ready.
        m_tready = 1'b1;
        for (int v = 0; v < 5; v++) begin
            clear_counters();
            send_cmd(vecs[v].addr, vecs[v].len, acc);
            drain("vec");
            check("vec_beats", beats, int'(vecs[v].len));
            check("vec_reads", rd_count, int'(vecs[v].len));
            check("vec_ready_low", ready_low, int'(vecs[v].len));
            if (vecs[v].len != '0) begin
                check("vec_first_lat", first_beat_cyc - acc, vecs[v].exp_lat);
                check("vec_last_lat", last_beat_cyc - acc, int'(vecs[v].len) + 2);
                check("vec_last_data", last_beat_data, vecs[v].exp_last_data);
                check("vec_busy_cycles", busy_cyc, int'(vecs[v].len) + 2);
                check("vec_lasts", lasts_seen, 1);
            end else begin
                check("noop_busy_cycles", busy_cyc, 0);
            end
        end

        // Backpressure: stream stalled from the start, held 10 cycles after first valid.
        clear_counters();
        m_tready = 1'b0;
        send_cmd(16'h0020, 17'd4, acc);
        t = 0;
        while (!m_tvalid && t < 20) begin
            @(posedge clk); #1;
            t++;
        end
        check("stall_first_valid", 32'(m_tvalid), 1);
        repeat (10) @(posedge clk);
        #1;
        check("stall_reads", rd_count, 3);
        check("stall_head_data", m_tdata, 16'h0020);
        check("stall_hold", stall_changed, 0);
        check("stall_no_beats", beats, 0);
        m_tready = 1'b1;
        rel = cyc;
        drain("stall");
        check("stall_resume", last_rd_cyc - rel, 1);
        check("stall_beats", beats, 4);
        check("stall_total_reads", rd_count, 4);

        // Back-to-back commands, second offered as soon as cmd_ready returns.
        clear_counters();
        send_cmd(16'h0040, 17'd3, acc);
        send_cmd(16'h0080, 17'd2, acc2);
        drain("b2b");
        check("b2b_ready_gap", acc2 - acc, 4);
        check("b2b_beats", beats, 5);
        check("b2b_lasts", lasts_seen, 2);
        check("b2b_last_data", last_beat_data, 16'h0081);

        // Reset mid-command with the FIFO full, then a clean command.
        clear_counters();
        m_tready = 1'b0;
        send_cmd(16'h0300, 17'd8, acc);
        repeat (6) @(posedge clk);
        #1;
        check("full_valid", 32'(m_tvalid), 1);
        check("full_reads", rd_count, 3);
        #3 rst_n = 1'b0;
        #1 check_reset_outputs("midrst");
        exp_q.delete();
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
        clear_counters();
        m_tready = 1'b1;
        send_cmd(16'h0500, 17'd2, acc);
        drain("post_rst");
        check("post_rst_beats", beats, 2);
        check("post_rst_first_lat", first_beat_cyc - acc, 3);
        check("post_rst_last_data", last_beat_data, 16'h0501);

        check("sb_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: bench did not finish within time limit");
        $fatal(1, "watchdog");
    end

endmodule
